adder8_seq_ctrl: RTL and testbench
==================================

Name: adder8_seq_ctrl

Overview:
- Sequencing controller that performs NBYTES-wide additions by time-multiplexing one external combinational 8-bit adder (ports a, b, c, sum, carry), least significant byte first, with the carry chained through a register.
- Sits between a requester (valid/ready request and result channels) and the shared 8-bit adder instance.
- Owns all adder inputs; the adder is instantiated alongside, not inside, this block.

Parameters:
- NBYTES, 4, number of 8-bit slices per operation (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  request valid.
- start_ready  output  1  controller can accept a request.
- op_a  input  8*NBYTES  operand A.
- op_b  input  8*NBYTES  operand B.
- op_cin  input  1  carry-in for byte 0.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res_sum  output  8*NBYTES  result.
- res_carry  output  1  carry-out of the top byte.
- busy  output  1  high in RUN or DONE.
- add_a  output  8  to adder a.
- add_b  output  8  to adder b.
- add_c  output  1  to adder c.
- add_sum  input  8  from adder sum.
- add_carry  input  1  from adder carry.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - Reset forces state IDLE, byte index 0, carry register 0, and operand and sum registers 0.
  - During and after reset: start_ready=1, res_valid=0, res_sum=0, res_carry=0, busy=0, add_a=0, add_b=0, add_c=0.
- FSM states IDLE, RUN, DONE (state register reset by rst_n only).
- IDLE:
  - start_ready=1; adder inputs driven 0.
  - On start_valid=1 at a clock edge: latch op_a, op_b and op_cin into the carry register; clear index to 0; go to RUN.
- RUN:
  - start_ready=0.
  - Adder inputs (combinational from registers): add_a = A byte[idx], add_b = B byte[idx], add_c = carry register.
  - Each edge: sum byte[idx] <= add_sum; carry register <= add_carry; idx <= idx+1.
  - On the edge that writes byte NBYTES-1: go to DONE; res_carry <= add_carry.
- DONE:
  - res_valid=1; res_sum/res_carry held stable; adder inputs driven 0.
  - On res_valid & res_ready: go to IDLE.
  - No request is accepted in that same cycle; start_ready rises the following cycle.
- Latency:
  - Request accepted at edge T; res_valid is high after edge T+NBYTES.
  - Exactly NBYTES RUN cycles. Throughput is one operation per NBYTES+2 cycles at minimum.
- start_valid is ignored outside IDLE; operands are sampled only at acceptance, so later changes to op_a/op_b have no effect.
- res_ready is ignored outside DONE.
- Result registers:
  - res_sum holds the last result in IDLE until the next acceptance.
  - Bytes are overwritten progressively during RUN; consumers use res_sum only while res_valid=1.
- Index counter is ceil(log2(NBYTES)) bits wide and never wraps past NBYTES-1.
- Asserting rst_n low mid-RUN or in DONE aborts immediately; the partial result is discarded and no res_valid pulse follows.
- busy = (state != IDLE).

Optional Feature:
- Macro ADDER_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), latched at acceptance.
  - When op_sub=1, B bytes are inverted before driving add_b, and the initial carry register is forced to 1 (op_cin ignored), giving A-B.
  - res_carry=1 means no borrow.
- Not defined: port op_sub is absent and the operation is always A+B+op_cin.

Test Plan:
1. NBYTES=4, op_a=0x000000FF, op_b=0x00000001, op_cin=0 -> res_sum=0x00000100, res_carry=0; res_valid rises 4 cycles after acceptance; add_c observed as 0,1,0,0 across the RUN cycles.
2. op_a=0xFFFFFFFF, op_b=0x00000001, op_cin=0 -> res_sum=0x00000000, res_carry=1.
3. op_a=0x12345678, op_b=0x87654321, op_cin=1 -> res_sum=0x9999999A, res_carry=0.
4. Hold res_ready=0 for 5 cycles in DONE while pulsing start_valid with new operands -> res_valid and res_sum held, start_ready=0, pulses ignored; after the handshake, start_ready=1 one cycle later.
5. Drive rst_n low after 2 RUN cycles -> all outputs 0 asynchronously, no res_valid; a following request op_a=1, op_b=2 returns 0x00000003.
6. With ADDER_SUB_EN: op_a=5, op_b=7, op_sub=1 -> res_sum=0xFFFFFFFE, res_carry=0; op_a=7, op_b=5 -> res_sum=0x00000002, res_carry=1.

Source files
------------

// File: rtl/adder8_seq_ctrl.sv
// rtl/adder8_seq_ctrl.sv - multi-byte add sequencer driving one shared external 8-bit adder (optional macro ADDER_SUB_EN)
module adder8_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  op_cin,
`ifdef ADDER_SUB_EN
    input  logic                  op_sub,
`endif
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   res_sum,
    output logic                  res_carry,
    output logic                  busy,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_c,
    input  logic [7:0]            add_sum,
    input  logic                  add_carry
);

    localparam int IDXW = $clog2(NBYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [IDXW-1:0]          idx;
    logic                     carry_q;
    logic                     res_carry_q;
    logic [NBYTES-1:0][7:0]   a_q;
    logic [NBYTES-1:0][7:0]   b_q;
    logic [NBYTES-1:0][7:0]   sum_q;
    logic [8*NBYTES-1:0]      b_eff;
    logic                     cin_eff;

    // Subtraction is folded in at acceptance: B is stored inverted and the carry seeded with 1.
    always_comb begin
`ifdef ADDER_SUB_EN
        b_eff   = op_sub ? ~op_b : op_b;
        cin_eff = op_sub ? 1'b1 : op_cin;
`else
        b_eff   = op_b;
        cin_eff = op_cin;
`endif
    end

    // Next-state logic and handshake/adder outputs.
    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        add_a       = 8'd0;
        add_b       = 8'd0;
        add_c       = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                add_a = a_q[idx];
                add_b = b_q[idx];
                add_c = carry_q;
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, operand latch, byte index and carry chain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            carry_q     <= 1'b0;
            res_carry_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= op_a;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx] <= add_sum;
                    carry_q    <= add_carry;
                    if (idx == LAST_IDX) begin
                        res_carry_q <= add_carry;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res_sum   = sum_q;
    assign res_carry = res_carry_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adder8_seq_ctrl.sv
// tb/tb_adder8_seq_ctrl.sv - directed self-checking bench for adder8_seq_ctrl
module tb_adder8_seq_ctrl;

    localparam int NBYTES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        op_cin = 1'b0;
    logic        op_sub = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_sum;
    logic        res_carry;
    logic        busy;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_c;
    logic [7:0]  add_sum;
    logic        add_carry;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] c_seen;

    always #5 clk = ~clk;

    assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_c};

    adder8_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_cin      (op_cin),
`ifdef ADDER_SUB_EN
        .op_sub      (op_sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_carry   (res_carry),
        .busy        (busy),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_c       (add_c),
        .add_sum     (add_sum),
        .add_carry   (add_carry)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (start_ready !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 20) check("start_ready_timeout", 64'(start_ready), 64'd1);
    endtask

    // Issues a request and walks the RUN cycles; returns with the DUT in DONE, sampled mid-cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        wait_ready();
        op_a = a;
        op_b = b;
        op_cin = cin;
        op_sub = sub;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op_a = ~a;
        op_b = ~b;
        for (int i = 0; i < NBYTES; i++) begin
            @(negedge clk);
            c_seen[i] = add_c;
            if (res_valid !== 1'b0 || busy !== 1'b1)
                check("run_flags", {62'd0, res_valid, busy}, 64'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("res_valid_latency", 64'(res_valid), 64'd1);
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_start_ready", 64'(start_ready), 64'd1);
        check("rst_outputs", {res_valid, res_sum, res_carry, busy, add_a, add_b, add_c}, 64'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: byte-0 carry ripples into byte 1
        issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        check("t1_sum", 64'(res_sum), 64'h00000100);
        check("t1_carry", 64'(res_carry), 64'd0);
        check("t1_add_c_seq", 64'(c_seen), 64'b0010);
        accept_result();
        @(negedge clk);
        check("t1_idle_ready", 64'(start_ready), 64'd1);
        check("t1_hold_sum", 64'(res_sum), 64'h00000100);

        // Test 2: full-width carry out
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        check("t2_sum", 64'(res_sum), 64'h00000000);
        check("t2_carry", 64'(res_carry), 64'd1);
        accept_result();

        // Test 3: carry-in
        issue(32'h12345678, 32'h87654321, 1'b1, 1'b0);
        check("t3_sum", 64'(res_sum), 64'h9999999A);
        check("t3_carry", 64'(res_carry), 64'd0);

        // Test 4: backpressure in DONE with start pulses
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            start_valid = (i % 2 == 0);
            op_a = 32'h11111111 * i;
            op_b = 32'h01010101;
            @(negedge clk);
            check("t4_hold", {res_valid, start_ready, res_sum, res_carry}, {1'b1, 1'b0, 32'h9999999A, 1'b0});
            @(posedge clk);
            #1;
        end
        start_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("t4_no_same_cycle_accept", {busy, start_ready, res_valid}, {1'b0, 1'b1, 1'b0});
        start_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t4_still_idle", 64'(busy), 64'd0);

        // Test 5: asynchronous abort mid-RUN
        wait_ready();
        op_a = 32'hA5A5A5A5;
        op_b = 32'h5A5A5A5A;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_reset", {res_valid, res_sum, res_carry, busy, add_a, add_b, add_c}, 64'd0);
        check("t5_ready", 64'(start_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) check("t5_no_valid", 64'(res_valid), 64'd0);
        end
        check("t5_idle_after", 64'(busy), 64'd0);
        issue(32'h00000001, 32'h00000002, 1'b0, 1'b0);
        check("t5_sum", 64'(res_sum), 64'h00000003);
        check("t5_carry", 64'(res_carry), 64'd0);
        accept_result();

`ifdef ADDER_SUB_EN
        // Test 6: subtraction
        issue(32'd5, 32'd7, 1'b0, 1'b1);
        check("t6_sub_neg", 64'(res_sum), 64'hFFFFFFFE);
        check("t6_borrow", 64'(res_carry), 64'd0);
        accept_result();
        issue(32'd7, 32'd5, 1'b0, 1'b1);
        check("t6_sub_pos", 64'(res_sum), 64'h00000002);
        check("t6_no_borrow", 64'(res_carry), 64'd1);
        accept_result();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
